// File: rtl/pipe_control_if.sv
// Pipeline-control bundle between the Y86-64 datapath (master) and pipe_control (slave).
// Hazard-relevant decode/execute/memory/writeback fields in, pipeline register controls out.
interface pipe_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    logic [3:0]       W_icode;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic [1:0]       pipe_state;
    logic [2:0]       cpu_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
               W_icode,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, pipe_state, cpu_stat,
               cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
               W_icode,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, pipe_state, cpu_stat,
               cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );
endinterface

// File: rtl/pipe_control.sv
// Y86-64 pipeline control: hazard detection, post-reset flush / run / halted sequencing
// and saturating performance counters.
module pipe_control #(
    parameter int unsigned FLUSH_CYCLES = 5,
    parameter int unsigned CNT_W        = 32
) (
    input logic           clk,
    input logic           rst,
    pipe_control_if.slave io_pipe
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int unsigned FW      = $clog2(FLUSH_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        StFlush  = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e           r_state;
    logic [FW-1:0]    r_flush_cnt;
    logic [2:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    logic w_loaduse;
    logic w_mispred;
    logic w_retp;
    logic w_mexc;
    logic w_wexc;
    logic w_retire;
    logic w_flush_done;

    assign w_loaduse = ((io_pipe.E_icode == I_MRMOVQ) || (io_pipe.E_icode == I_POPQ)) &&
                       (io_pipe.E_dstM != RNONE) &&
                       ((io_pipe.E_dstM == io_pipe.d_srcA) || (io_pipe.E_dstM == io_pipe.d_srcB));
    assign w_mispred = (io_pipe.E_icode == I_JXX) && !io_pipe.e_Cnd;
    assign w_retp    = (io_pipe.D_icode == I_RET) || (io_pipe.E_icode == I_RET) ||
                       (io_pipe.M_icode == I_RET);
    assign w_mexc    = (io_pipe.m_stat == STAT_HLT) || (io_pipe.m_stat == STAT_ADR) ||
                       (io_pipe.m_stat == STAT_INS);
    assign w_wexc    = (io_pipe.W_stat == STAT_HLT) || (io_pipe.W_stat == STAT_ADR) ||
                       (io_pipe.W_stat == STAT_INS);
    // Bubbles carry icode NOP, so excluding NOP drops both bubbles and real nops.
    assign w_retire  = (io_pipe.W_stat == STAT_AOK) && (io_pipe.W_icode != I_NOP);
    // Widened compare so FLUSH_CYCLES=0 leaves FLUSH on the first clock after reset.
    assign w_flush_done = (32'(r_flush_cnt) + 32'd1) >= FLUSH_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StFlush;
            r_flush_cnt <= '0;
            r_cpu_stat  <= STAT_AOK;
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_lu_cnt    <= '0;
            r_mp_cnt    <= '0;
        end else begin
            unique case (r_state)
                StFlush: begin
                    if (w_flush_done) begin
                        r_state <= StRun;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FW'(1);
                    end
                end
                StRun: begin
                    if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                    if (w_retire && (r_ret_cnt != '1)) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                    if (w_loaduse && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
                    if (w_mispred && (r_mp_cnt != '1)) r_mp_cnt <= r_mp_cnt + CNT_W'(1);
                    if (w_wexc) begin
                        r_state    <= StHalted;
                        r_cpu_stat <= io_pipe.W_stat;
                    end
                end
                StHalted: begin
                    r_state <= StHalted;
                end
                default: begin
                    r_state <= StFlush;
                end
            endcase
        end
    end

    always_comb begin
        io_pipe.F_stall  = 1'b0;
        io_pipe.D_stall  = 1'b0;
        io_pipe.D_bubble = 1'b1;
        io_pipe.E_bubble = 1'b1;
        io_pipe.M_bubble = 1'b1;
        io_pipe.W_stall  = 1'b0;
        unique case (r_state)
            StRun: begin
                io_pipe.F_stall  = w_loaduse || w_retp;
                io_pipe.D_stall  = w_loaduse;
                // A stalled decode register must never also be bubbled.
                io_pipe.D_bubble = (w_mispred || (w_retp && !w_loaduse)) && !w_loaduse;
                io_pipe.E_bubble = w_mispred || w_loaduse;
                io_pipe.M_bubble = w_mexc || w_wexc;
                io_pipe.W_stall  = w_wexc;
            end
            StHalted: begin
                io_pipe.F_stall  = 1'b1;
                io_pipe.D_stall  = 1'b1;
                io_pipe.D_bubble = 1'b0;
                io_pipe.E_bubble = 1'b1;
                io_pipe.M_bubble = 1'b1;
                io_pipe.W_stall  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign io_pipe.pipe_state = r_state;
    assign io_pipe.cpu_stat   = r_cpu_stat;
    assign io_pipe.cyc_cnt    = r_cyc_cnt;
    assign io_pipe.ret_cnt    = r_ret_cnt;
    assign io_pipe.lu_cnt     = r_lu_cnt;
    assign io_pipe.mp_cnt     = r_mp_cnt;
endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: a default instance (FLUSH_CYCLES=5, CNT_W=32) and a
// narrow instance (FLUSH_CYCLES=0, CNT_W=4) for the saturation corner.
module tb_pipe_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    int   exp_cyc = 0;

    always #5 clk = ~clk;

    pipe_control_if #(.CNT_W(32)) bus_a ();
    pipe_control_if #(.CNT_W(4))  bus_b ();

    pipe_control #(.FLUSH_CYCLES(5), .CNT_W(32)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .io_pipe (bus_a)
    );

    pipe_control #(.FLUSH_CYCLES(0), .CNT_W(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .io_pipe (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}.
    function automatic logic [31:0] ctl_a();
        return {26'd0, bus_a.F_stall, bus_a.D_stall, bus_a.D_bubble, bus_a.E_bubble,
                bus_a.M_bubble, bus_a.W_stall};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_run();
        tick();
        exp_cyc++;
    endtask

    task automatic idle_a();
        bus_a.D_icode = 4'h1;
        bus_a.E_icode = 4'h1;
        bus_a.M_icode = 4'h1;
        bus_a.W_icode = 4'h1;
        bus_a.d_srcA  = 4'hF;
        bus_a.d_srcB  = 4'hF;
        bus_a.E_dstM  = 4'hF;
        bus_a.e_Cnd   = 1'b1;
        bus_a.m_stat  = 3'd1;
        bus_a.W_stat  = 3'd1;
    endtask

    initial begin
        idle_a();
        bus_b.D_icode = 4'h1;
        bus_b.E_icode = 4'h1;
        bus_b.M_icode = 4'h1;
        bus_b.W_icode = 4'h6;
        bus_b.d_srcA  = 4'hF;
        bus_b.d_srcB  = 4'hF;
        bus_b.E_dstM  = 4'hF;
        bus_b.e_Cnd   = 1'b1;
        bus_b.m_stat  = 3'd1;
        bus_b.W_stat  = 3'd1;

        // Reset and flush window
        tick();
        rst = 1'b0;
        check("rst_cpu_stat", 32'(bus_a.cpu_stat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("flush_state_%0d", i), 32'(bus_a.pipe_state), 32'd0);
            check($sformatf("flush_ctl_%0d", i), ctl_a(), 32'b001110);
            tick();
        end
        check("run_state", 32'(bus_a.pipe_state), 32'd1);
        check("run_idle_ctl", ctl_a(), 32'b000000);
        check("run_cyc0", bus_a.cyc_cnt, 32'd0);
        check("run_cpu_stat", 32'(bus_a.cpu_stat), 32'd1);
        tick_run();
        tick_run();
        check("cyc_inc", bus_a.cyc_cnt, 32'(exp_cyc));

        // Load-use on srcB, then same with RNONE destination
        bus_a.E_icode = 4'h5;
        bus_a.E_dstM  = 4'h3;
        bus_a.d_srcB  = 4'h3;
        #1;
        check("lu_ctl", ctl_a(), 32'b110100);
        tick_run();
        check("lu_cnt1", bus_a.lu_cnt, 32'd1);
        bus_a.E_dstM = 4'hF;
        #1;
        check("lu_rnone_ctl", ctl_a(), 32'b000000);
        tick_run();
        check("lu_rnone_cnt", bus_a.lu_cnt, 32'd1);

        // Mispredict together with ret in decode
        idle_a();
        bus_a.E_icode = 4'h7;
        bus_a.e_Cnd   = 1'b0;
        bus_a.D_icode = 4'h9;
        #1;
        check("mp_ret_ctl", ctl_a(), 32'b101100);
        tick_run();
        check("mp_cnt1", bus_a.mp_cnt, 32'd1);
        bus_a.e_Cnd = 1'b1;
        #1;
        check("taken_ret_ctl", ctl_a(), 32'b101000);
        tick_run();
        check("mp_cnt_hold", bus_a.mp_cnt, 32'd0 + 32'd1);

        // Ret with load-use: decode stall wins over bubble
        idle_a();
        bus_a.D_icode = 4'h9;
        bus_a.E_icode = 4'hB;
        bus_a.E_dstM  = 4'h4;
        bus_a.d_srcA  = 4'h4;
        #1;
        check("ret_lu_ctl", ctl_a(), 32'b110100);
        tick_run();
        check("lu_cnt2", bus_a.lu_cnt, 32'd2);

        // Three genuine retirements
        idle_a();
        bus_a.W_icode = 4'h6;
        tick_run();
        tick_run();
        tick_run();
        bus_a.W_icode = 4'h1;
        #1;
        check("ret_cnt3", bus_a.ret_cnt, 32'd3);

        // Memory exception, then writeback exception
        bus_a.m_stat = 3'd3;
        #1;
        check("mexc_ctl", ctl_a(), 32'b000010);
        tick_run();
        bus_a.m_stat  = 3'd1;
        bus_a.W_stat  = 3'd3;
        bus_a.W_icode = 4'h6;
        #1;
        check("wexc_ctl", ctl_a(), 32'b000011);
        check("wexc_state", 32'(bus_a.pipe_state), 32'd1);
        tick_run();
        check("halt_state", 32'(bus_a.pipe_state), 32'd2);
        check("halt_cpu_stat", 32'(bus_a.cpu_stat), 32'd3);
        check("halt_ctl", ctl_a(), 32'b110111);
        check("halt_cyc", bus_a.cyc_cnt, 32'(exp_cyc));
        check("halt_ret", bus_a.ret_cnt, 32'd3);

        // Activity while halted must not move anything
        bus_a.W_stat  = 3'd1;
        bus_a.E_icode = 4'h5;
        bus_a.E_dstM  = 4'h2;
        bus_a.d_srcA  = 4'h2;
        for (int i = 0; i < 10; i++) tick();
        check("frz_state", 32'(bus_a.pipe_state), 32'd2);
        check("frz_cpu_stat", 32'(bus_a.cpu_stat), 32'd3);
        check("frz_cyc", bus_a.cyc_cnt, 32'(exp_cyc));
        check("frz_ret", bus_a.ret_cnt, 32'd3);
        check("frz_lu", bus_a.lu_cnt, 32'd2);
        check("frz_mp", bus_a.mp_cnt, 32'd1);
        check("frz_ctl", ctl_a(), 32'b110111);

        // Reset out of HALTED
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerst_state", 32'(bus_a.pipe_state), 32'd0);
        check("rerst_cpu_stat", 32'(bus_a.cpu_stat), 32'd1);
        check("rerst_cyc", bus_a.cyc_cnt, 32'd0);
        check("rerst_ret", bus_a.ret_cnt, 32'd0);
        check("rerst_lu", bus_a.lu_cnt, 32'd0);
        check("rerst_mp", bus_a.mp_cnt, 32'd0);
        check("rerst_ctl", ctl_a(), 32'b001110);

        // Narrow instance: zero flush cycles, 4-bit saturation
        tick();
        rst_b = 1'b0;
        check("b_flush_state", 32'(bus_b.pipe_state), 32'd0);
        tick();
        check("b_run_state", 32'(bus_b.pipe_state), 32'd1);
        check("b_cyc0", 32'(bus_b.cyc_cnt), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("b_cyc10", 32'(bus_b.cyc_cnt), 32'd10);
        check("b_ret10", 32'(bus_b.ret_cnt), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        check("b_cyc_sat", 32'(bus_b.cyc_cnt), 32'd15);
        check("b_ret_sat", 32'(bus_b.ret_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
